truncador_saturador: RTL and testbench
======================================

Name: truncador_saturador

Overview:
- Return-path counterpart of the sum-extension stage: takes a 2N-bit extended/accumulated fixed-point value and reduces it back to an N-bit signed word.
- Reduction steps: arithmetic right shift by FRAC, round-half-up, then saturation to the N-bit signed range.
- 2-stage pipeline with valid/ready handshake, sticky overflow flag and saturation event counter.
- Sits between the wide accumulator/multiplier datapath and the N-bit filter/output registers.

Parameters:
- N, 25: output word width; input width is 2N.
- FRAC, 10: fractional bits discarded (right-shift amount); legal range 1 to N-1.
- CW, 8: width of the saturation event counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  2N  signed two's-complement extended value.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  N  signed rounded, saturated result.
- sat_now  output  1  qualifies out_data: this result was clipped.
- sat_sticky  output  1  a clip occurred since the last clear or reset.
- sat_count  output  CW  number of clipped results; holds at all-ones.
- clr_sat  input  1  synchronous clear of sat_sticky and sat_count.

Behaviour:
- Reset values (asynchronous): out_valid=0, out_data=0, sat_now=0, sat_sticky=0, sat_count=0, and both stage valid bits 0.
- Advance enable: adv = ~out_valid | out_ready.
  - in_ready = adv (combinational).
  - Transfer occurs when in_valid & in_ready.
- Stage 1, registered on adv:
  - r1 = sign-extend(in_data) to 2N+1 bits, plus 2^(FRAC-1).
  - The extra bit guarantees the add never wraps.
  - v1 = in_valid & in_ready.
- Stage 2, registered on adv:
  - q = r1 >>> FRAC (arithmetic shift).
  - If q > 2^(N-1)-1: out_data = 2^(N-1)-1, sat_now = 1.
  - If q < -2^(N-1): out_data = -2^(N-1), sat_now = 1.
  - Otherwise: out_data = q[N-1:0], sat_now = 0.
  - out_valid takes v1.
- Latency: exactly 2 cycles from accepted input to out_valid when out_ready is held high.
  - Throughput: 1 result per cycle.
- Stall: when out_valid & ~out_ready, both stages hold their contents and in_ready = 0.
  - No data is lost or duplicated.
  - out_data, out_valid and sat_now stay stable until accepted.
- Bubbles: an empty stage 1 (v1 = 0) propagates as out_valid = 0 on the next advance.
- Rounding is round-half-up, toward +infinity on ties:
  - +1.5 -> 2
  - -1.5 -> -1
  - -2.5 -> -2
- Saturation statistics:
  - Updated only when a saturated result is transferred (out_valid & out_ready & sat_now).
  - On such a transfer: sat_sticky <= 1, and sat_count increments unless already all-ones.
- clr_sat:
  - Clears sat_sticky and sat_count the next cycle.
  - If a saturated transfer happens in the same cycle, clr_sat wins: both end at 0.
- Reset mid-operation: all in-flight data is discarded; the first output after reset release comes from a fresh transfer.

Decomposition:
- Shared fixed-point package/include holds:
  - N and FRAC defaults, shared with the sum-extension stage.
  - Constants SAT_MAX = 2^(N-1)-1 and SAT_MIN = -2^(N-1).
  - The rounding constant 2^(FRAC-1).
- One natural combinational sub-module, saturador_n: maps the (2N+1-FRAC)-bit q to an N-bit value plus the sat flag.
- Pipeline registers, handshake and counter stay in the top module.

Test Plan (N=25, FRAC=10, out_ready=1 unless stated):
- Rounding: inputs 1024, 1536, 511, 512, -1536, sent back-to-back -> out_data 1, 2, 0, 1, -1, on cycles 2 to 6 after the first input; sat_now = 0 throughout.
- Positive saturation: input 2^34 -> out_data 0x0FFFFFF, sat_now = 1, sat_sticky = 1, sat_count = 1. Also input (2^24-1)*1024+512 (rounds up over range) -> 0x0FFFFFF, sat_count = 2.
- Negative saturation: input -2^40 -> out_data 0x1000000 (-2^24), sat_now = 1. Input -2^34 -> 0x1000000 with sat_now = 0 (exactly in range).
- Backpressure: stream values 1024*k for k = 1..6 while holding out_ready = 0 for 3 cycles mid-stream:
  - in_ready drops for those cycles.
  - The output sequence is exactly 1..6: no drops, no repeats.
  - out_data is stable while stalled.
- Counter and clear:
  - 260 saturating inputs -> sat_count holds at 255.
  - clr_sat asserted in the same cycle as a saturated transfer -> sat_count = 0 and sat_sticky = 0 next cycle.
- Asynchronous reset asserted with both stages full and a stall active:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the first result appears 2 cycles after the next accepted input.

Source files
------------

// File: rtl/truncador_saturador_pkg.sv
// Shared fixed-point defaults for the sum-extension / truncation pair,
// plus the saturation limits and rounding constant at the default widths.
package truncador_saturador_pkg;

  localparam int N_DEF    = 25;
  localparam int FRAC_DEF = 10;
  localparam int CW_DEF   = 8;

  localparam logic [N_DEF-1:0] SAT_MAX = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic [N_DEF-1:0] SAT_MIN = {1'b1, {(N_DEF-1){1'b0}}};

  localparam logic [2*N_DEF:0] ROUND_K =
    {{(2*N_DEF){1'b0}}, 1'b1} << (FRAC_DEF - 1);

endpackage

// File: rtl/truncador_saturador_saturador_n.sv
// Clips a (2N+1-FRAC)-bit signed value to the N-bit signed range and
// reports whether clipping occurred.
module saturador_n #(
  parameter int N    = 25,
  parameter int FRAC = 10
) (
  input  logic [2*N-FRAC:0] q_i,
  output logic [N-1:0]      data_o,
  output logic              sat_o
);

  localparam int QW = 2*N + 1 - FRAC;

  localparam logic [N-1:0] MAX_P = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_P = {1'b1, {(N-1){1'b0}}};

  // The value fits iff every bit from the output sign bit upward matches.
  logic [QW-N:0] upper;
  logic          ovf;

  assign upper = q_i[QW-1:N-1];
  assign ovf   = (|upper) & ~(&upper);

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    data_o = q_i[N-1:0];
    sat_o  = 1'b0;
    if (ovf) begin
      sat_o  = 1'b1;
      data_o = q_i[QW-1] ? MIN_P : MAX_P;
    end
  end

endmodule

// File: rtl/truncador_saturador.sv
// Two-stage round-and-saturate reducer from a 2N-bit accumulator value to an
// N-bit signed word, with valid/ready flow control and clip statistics.
module truncador_saturador
  import truncador_saturador_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2*N-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          sat_now,
  output logic          sat_sticky,
  output logic [CW-1:0] sat_count,
  input  logic          clr_sat
);

  localparam logic [2*N:0] RND = {{(2*N){1'b0}}, 1'b1} << (FRAC - 1);

  logic            adv;
  logic [2*N:0]    r1_d, r1_q;
  logic            v1_q;
  logic [N-1:0]    sat_data;
  logic            sat_flag;
  logic [N-1:0]    out_data_q;
  logic            out_valid_q;
  logic            sat_now_q;
  logic            sat_sticky_d, sat_sticky_q;
  logic [CW-1:0]   sat_count_d, sat_count_q;
  logic            sat_xfer;

  // Both stages move together; a stalled output freezes the whole pipe.
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  // One guard bit above the sign extension keeps the rounding add exact.
  assign r1_d = {in_data[2*N-1], in_data} + RND;

  // Stage 1: sign-extend and add the half-LSB rounding constant.
  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_q <= '0;
      v1_q <= 1'b0;
    end else if (adv) begin
      r1_q <= r1_d;
      v1_q <= in_valid;
    end
  end

  // The arithmetic shift by FRAC is just the upper slice of r1.
  saturador_n #(
    .N    (N),
    .FRAC (FRAC)
  ) u_sat (
    .q_i    (r1_q[2*N:FRAC]),
    .data_o (sat_data),
    .sat_o  (sat_flag)
  );

  logic unused_round_bits;
  assign unused_round_bits = ^r1_q[FRAC-1:0];

  // Stage 2: output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_now_q   <= 1'b0;
    end else if (adv) begin
      out_data_q  <= sat_data;
      out_valid_q <= v1_q;
      sat_now_q   <= sat_flag;
    end
  end

  assign sat_xfer = out_valid_q & out_ready & sat_now_q;

  // Clear takes priority over a clip landing in the same cycle.
  always_comb begin
    sat_sticky_d = sat_sticky_q;
    sat_count_d  = sat_count_q;
    if (clr_sat) begin
      sat_sticky_d = 1'b0;
      sat_count_d  = '0;
    end else if (sat_xfer) begin
      sat_sticky_d = 1'b1;
      if (!(&sat_count_q)) begin
        sat_count_d = sat_count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_sticky_q <= 1'b0;
      sat_count_q  <= '0;
    end else begin
      sat_sticky_q <= sat_sticky_d;
      sat_count_q  <= sat_count_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign sat_now    = sat_now_q;
  assign sat_sticky = sat_sticky_q;
  assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_truncador_saturador.sv
// Directed bench for truncador_saturador: vector table for rounding and
// saturation, then backpressure, counter/clear and async-reset sequences.
module tb_truncador_saturador;

  localparam int N    = 25;
  localparam int FRAC = 10;
  localparam int CW   = 8;
  localparam int W    = 2*N;
  localparam int NV   = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          sat_now;
  logic          sat_sticky;
  logic [CW-1:0] sat_count;
  logic          clr_sat;

  always #5 clk = ~clk;

  truncador_saturador #(.N(N), .FRAC(FRAC), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sat_now    (sat_now),
    .sat_sticky (sat_sticky),
    .sat_count  (sat_count),
    .clr_sat    (clr_sat)
  );

  typedef struct {
    logic [W-1:0] din;
    logic [N-1:0] dout;
    logic         sat;
  } vec_t;

  vec_t tbl [NV];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input longint din, input longint dout, input logic sat);
    vec_t v;
    v.din  = din[W-1:0];
    v.dout = dout[N-1:0];
    v.sat  = sat;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rx[$];
    logic [N-1:0] prev_data;
    logic         prev_stall;
    int           sent;
    int           model_cnt;

    tbl[0]  = mk(1024, 1, 1'b0);
    tbl[1]  = mk(1536, 2, 1'b0);
    tbl[2]  = mk(511, 0, 1'b0);
    tbl[3]  = mk(512, 1, 1'b0);
    tbl[4]  = mk(-1536, -1, 1'b0);
    tbl[5]  = mk(-2560, -2, 1'b0);
    tbl[6]  = mk(64'd17179868160, 64'h0FFFFFF, 1'b0);
    tbl[7]  = mk(64'd17179869184, 64'h0FFFFFF, 1'b1);
    tbl[8]  = mk(64'd17179868672, 64'h0FFFFFF, 1'b1);
    tbl[9]  = mk(-64'sd1099511627776, -64'sd16777216, 1'b1);
    tbl[10] = mk(-64'sd17179869184, -64'sd16777216, 1'b0);
    tbl[11] = mk(-64'sd17179869697, -64'sd16777216, 1'b1);

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    clr_sat   = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sat_now", sat_now, 0);
    check("rst_sat_sticky", sat_sticky, 0);
    check("rst_sat_count", sat_count, 0);
    reset = 1'b0;
    step();

    // Back-to-back table stream; result of vector i is visible after edge i+1.
    model_cnt = 0;
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        in_valid = 1'b1;
        in_data  = tbl[i].din;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i == 0) begin
        check("latency_no_early_valid", out_valid, 0);
      end else begin
        check($sformatf("vec%0d_valid", i-1), out_valid, 1);
        check($sformatf("vec%0d_data", i-1), out_data, tbl[i-1].dout);
        check($sformatf("vec%0d_sat_now", i-1), sat_now, tbl[i-1].sat);
        check($sformatf("vec%0d_count", i-1), sat_count, model_cnt);
        check($sformatf("vec%0d_sticky", i-1), sat_sticky, model_cnt != 0);
        if (tbl[i-1].sat) model_cnt++;
      end
    end
    step();
    check("tbl_bubble_valid", out_valid, 0);
    check("tbl_final_count", sat_count, model_cnt);
    check("tbl_final_sticky", sat_sticky, 1);

    // Backpressure: six values with out_ready low for three cycles.
    sent       = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int cyc = 0; cyc < 40 && rx.size() < 6; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid  = (sent < 6);
      in_data   = W'(1024 * (sent + 1));
      #1;
      if (out_valid && !out_ready) check("bp_in_ready_low", in_ready, 0);
      if (prev_stall) begin
        check("bp_stable_valid", out_valid, 1);
        check("bp_stable_data", out_data, prev_data);
      end
      if (out_valid && out_ready) rx.push_back(out_data);
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      step();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check("bp_rx_count", rx.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < rx.size()) check($sformatf("bp_rx%0d", k), rx[k], k + 1);
    end

    // Counter saturation at all-ones.
    in_valid = 1'b1;
    in_data  = W'(64'd17179869184);
    for (int k = 0; k < 260; k++) step();
    in_valid = 1'b0;
    step();
    step();
    step();
    check("cnt_hold_255", sat_count, 8'hFF);
    check("cnt_sticky", sat_sticky, 1);

    // clr_sat coincident with a saturated transfer.
    in_valid = 1'b1;
    in_data  = W'(64'd17179869184);
    step();
    in_valid = 1'b0;
    step();
    check("clr_pre_valid", out_valid, 1);
    check("clr_pre_sat_now", sat_now, 1);
    clr_sat = 1'b1;
    step();
    clr_sat = 1'b0;
    check("clr_count", sat_count, 0);
    check("clr_sticky", sat_sticky, 0);

    // Async reset with both stages full and the output stalled.
    in_valid = 1'b1;
    in_data  = W'(64'd17179869184);
    step();
    in_valid = 1'b0;
    step();
    step();
    check("ar_pre_sticky", sat_sticky, 1);
    check("ar_pre_count", sat_count, 1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(64'd17179869184);
    step();
    in_data   = W'(2048);
    step();
    in_valid  = 1'b0;
    check("ar_stall_valid", out_valid, 1);
    check("ar_stall_sat_now", sat_now, 1);
    check("ar_stall_in_ready", in_ready, 0);
    #2 reset = 1'b1;
    #1;
    check("ar_async_valid", out_valid, 0);
    check("ar_async_data", out_data, 0);
    check("ar_async_sat_now", sat_now, 0);
    check("ar_async_sticky", sat_sticky, 0);
    check("ar_async_count", sat_count, 0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    check("ar_no_stale_valid", out_valid, 0);
    in_valid = 1'b1;
    in_data  = W'(3072);
    step();
    in_valid = 1'b0;
    check("ar_fresh_early_valid", out_valid, 0);
    step();
    check("ar_fresh_valid", out_valid, 1);
    check("ar_fresh_data", out_data, 3);
    check("ar_fresh_sat_now", sat_now, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
